// File: rtl/traveler_cmd_encoder.sv
// Button-to-command encoder: sync, debounce, single-press filter,
// toggle-marked command word with optional hold-to-repeat.
module traveler_cmd_encoder #(
  parameter int                       N_BTN         = 5,
  parameter int                       CMD_W         = 8,
  parameter logic [N_BTN*CMD_W-1:0]   CMD_TABLE     = 40'h0A_06_12_42_22,
  parameter int                       DEBOUNCE_CNT  = 5000000,
  parameter bit                       REPEAT_EN     = 1'b0,
  parameter int                       REPEAT_DELAY  = 50000000,
  parameter int                       REPEAT_PERIOD = 10000000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_BTN-1:0]             button,
  output logic [CMD_W:0]               data,
  output logic                         cmd_valid,
  output logic [$clog2(N_BTN+1)-1:0]   cmd_id
);

  localparam int IDW  = $clog2(N_BTN+1);
  localparam int MAX1 = (DEBOUNCE_CNT > REPEAT_DELAY) ?
                        DEBOUNCE_CNT : REPEAT_DELAY;
  localparam int MAXC = (MAX1 > REPEAT_PERIOD) ? MAX1 : REPEAT_PERIOD;
  localparam int CW   = $clog2(MAXC+1);

  localparam logic [CW-1:0] DB_C  = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] RD_C  = CW'(REPEAT_DELAY-1);
  localparam logic [CW-1:0] RP_C  = CW'(REPEAT_PERIOD-1);
  localparam logic [CW-1:0] CNT_M = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HELD
  } state_t;

  state_t             state_q, state_d;
  logic [N_BTN-1:0]   s1_q, s_q;
  logic [IDW-1:0]     cand_q, cand_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               first_q, first_d;
  logic [CMD_W:0]     data_q;
  logic               valid_q;
  logic [IDW-1:0]     id_q;

  logic               single;
  logic [IDW-1:0]     sid;
  logic [CMD_W-1:0]   cmd_w;
  logic [CW-1:0]      thr;
  logic               emit;

  always_comb begin
    sid   = '0;
    cmd_w = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (s_q[i]) sid = IDW'(i+1);
      if (cand_q == IDW'(i+1))
        cmd_w = CMD_TABLE[i*CMD_W +: CMD_W];
    end
  end

  assign single = $onehot(s_q);
  assign thr    = first_q ? RD_C : RP_C;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    emit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (single) begin
          state_d = ARM;
          cand_d  = sid;
          cnt_d   = '0;
        end
      end
      ARM: begin
        if (!single) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sid != cand_q) begin
          cand_d = sid;
          cnt_d  = '0;
        end else if (cnt_q == DB_C) begin
          emit    = 1'b1;
          state_d = HELD;
          cnt_d   = '0;
          first_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!single) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (sid != cand_q) begin
          state_d = ARM;
          cand_d  = sid;
          cnt_d   = '0;
        end else if (REPEAT_EN && cnt_q == thr) begin
          emit    = 1'b1;
          cnt_d   = '0;
          first_d = 1'b0;
        end else if (cnt_q != CNT_M) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= '0;
      s_q     <= '0;
      state_q <= IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      s1_q    <= button;
      s_q     <= s1_q;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      valid_q <= emit;
      // mark flips on every emission so repeats of one command are visible
      if (emit) begin
        data_q <= {~data_q[CMD_W], cmd_w};
        id_q   <= cand_q;
      end
    end
  end

  assign data      = data_q;
  assign cmd_valid = valid_q;
  assign cmd_id    = id_q;

endmodule
